// File: rtl/pe_feed_pkg.sv
// rtl/pe_feed_pkg.sv - shared widths, state type and index constants for the PE operand feeder
package pe_feed_pkg;

    localparam int IWIDTH = 8;
    localparam int IDEPTH = 3;
    localparam int KWIDTH = 16;

    // Final bit-serial cycle of a MAC, and the cycle just before it.
    localparam logic [IDEPTH-1:0] LAST_IDX = IDEPTH'(IWIDTH - 1);
    localparam logic [IDEPTH-1:0] PEN_IDX  = IDEPTH'(IWIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } pe_feed_state_t;

endpackage

// File: rtl/pe_feed_inner_if.sv
// rtl/pe_feed_inner_if.sv - operand-pair valid/ready stream into the PE feeder
interface pe_feed_inner_if;
    import pe_feed_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [IWIDTH-1:0] in_ifm;
    logic signed [IWIDTH-1:0] in_wght;

    modport master (
        output in_valid,
        output in_ifm,
        output in_wght,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_ifm,
        input  in_wght,
        output in_ready
    );

endinterface

// File: rtl/pe_feed_idx_cnt.sv
// rtl/pe_feed_idx_cnt.sv - bit-serial index counter with clear, enable and last-cycle flag
module pe_feed_idx_cnt #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    logic [WIDTH-1:0] r_cnt;

    // Clear has priority so a new MAC always restarts at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/pe_feed_inner.sv
// rtl/pe_feed_inner.sv - PE operand feeder/sequencer; define PE_FEED_STALL_CNT_EN to add the stall_cnt output
module pe_feed_inner
    import pe_feed_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KWIDTH-1:0]        cfg_k,
    output logic                     busy,
    output logic                     done,
    pe_feed_inner_if.slave           s_in,
    output logic [IDEPTH-1:0]        idx,
    output logic                     mac_done,
    output logic                     en_i,
    output logic                     en_w,
    output logic                     clr_i,
    output logic                     clr_w,
    output logic                     en_o,
    output logic                     clr_o,
    output logic signed [IWIDTH-1:0] ifm,
    output logic signed [IWIDTH-1:0] wght
`ifdef PE_FEED_STALL_CNT_EN
    ,
    output logic [KWIDTH-1:0]        stall_cnt
`endif
);

    pe_feed_state_t           r_state;
    logic [KWIDTH-1:0]        r_k_left;
    logic                     r_first;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_mac_done;
    logic                     r_en_i;
    logic                     r_en_w;
    logic                     r_clr_i;
    logic                     r_clr_w;
    logic                     r_en_o;
    logic                     r_clr_o;
    logic signed [IWIDTH-1:0] r_ifm;
    logic signed [IWIDTH-1:0] r_wght;

    logic [IDEPTH-1:0]        w_cnt;
    logic                     w_last;
    logic                     w_cnt_en;
    logic                     w_cnt_clr;
    logic                     w_k_nz;
    logic                     w_in_ready;
    logic                     w_hs;

    // A new pair is taken while waiting in LOAD, or on the last bit cycle
    // of a MAC when more MACs remain, which keeps back-to-back MACs gapless.
    assign w_k_nz     = (r_k_left != '0);
    assign w_in_ready = (r_state == LOAD) || ((r_state == RUN) && w_last && w_k_nz);
    assign w_hs       = s_in.in_valid && w_in_ready;
    assign s_in.in_ready = w_in_ready;

    // The index only advances inside a MAC; everywhere else it parks at 0.
    assign w_cnt_en  = (r_state == RUN) && !w_last;
    assign w_cnt_clr = !w_cnt_en;

    pe_feed_idx_cnt #(
        .WIDTH (IDEPTH),
        .LAST  (LAST_IDX)
    ) u_idx_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    // Job sequencing: state, remaining MAC count, operand capture and the
    // registered PE controls, which are set on the edge entering their cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_k_left   <= '0;
            r_first    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mac_done <= 1'b0;
            r_en_i     <= 1'b0;
            r_en_w     <= 1'b0;
            r_clr_i    <= 1'b0;
            r_clr_w    <= 1'b0;
            r_en_o     <= 1'b0;
            r_clr_o    <= 1'b0;
            r_ifm      <= '0;
            r_wght     <= '0;
        end else begin
            r_en_i     <= 1'b0;
            r_en_w     <= 1'b0;
            r_en_o     <= 1'b0;
            r_clr_o    <= 1'b0;
            r_mac_done <= 1'b0;
            r_done     <= 1'b0;
            r_clr_i    <= 1'b0;
            r_clr_w    <= 1'b0;
            if (w_hs) begin
                // Pair accepted: next cycle is bit 0 of a fresh MAC.
                r_ifm      <= s_in.in_ifm;
                r_wght     <= s_in.in_wght;
                r_k_left   <= r_k_left - 1'b1;
                r_state    <= RUN;
                r_en_i     <= 1'b1;
                r_en_w     <= 1'b1;
                r_en_o     <= 1'b1;
                r_clr_o    <= r_first;
                r_first    <= 1'b0;
                r_mac_done <= (LAST_IDX == IDEPTH'(0));
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_busy <= 1'b1;
                            if (cfg_k != '0) begin
                                r_k_left <= cfg_k;
                                r_first  <= 1'b1;
                                r_state  <= LOAD;
                            end else begin
                                r_state  <= FIN;
                            end
                        end
                    end
                    LOAD: begin
                        r_state <= LOAD;
                    end
                    RUN: begin
                        if (!w_last) begin
                            r_en_o     <= 1'b1;
                            r_mac_done <= (w_cnt == PEN_IDX);
                        end else if (w_k_nz) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_clr_i <= 1'b1;
                            r_clr_w <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    FIN: begin
                        // An empty job arrives here with done still low and
                        // spends one extra cycle to raise it.
                        if (r_done) begin
                            r_state <= IDLE;
                        end else begin
                            r_done  <= 1'b1;
                            r_clr_i <= 1'b1;
                            r_clr_w <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PE_FEED_STALL_CNT_EN
    logic [KWIDTH-1:0] r_stall_cnt;

    // Saturating count of cycles spent waiting in LOAD for an operand pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == LOAD) && !s_in.in_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign idx      = w_cnt;
    assign mac_done = r_mac_done;
    assign en_i     = r_en_i;
    assign en_w     = r_en_w;
    assign clr_i    = r_clr_i;
    assign clr_w    = r_clr_w;
    assign en_o     = r_en_o;
    assign clr_o    = r_clr_o;
    assign ifm      = r_ifm;
    assign wght     = r_wght;

endmodule

// File: tb/tb_pe_feed_inner.sv
// tb/tb_pe_feed_inner.sv - self-checking bench for pe_feed_inner
`timescale 1ns/1ps
module tb_pe_feed_inner;

    localparam int IW    = 8;
    localparam int KW    = 16;
    localparam int NEVER = 32'h3fffffff;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [KW-1:0]        cfg_k;
    logic                 busy, done, mac_done, en_i, en_w, clr_i, clr_w, en_o, clr_o;
    logic [2:0]           idx;
    logic signed [IW-1:0] ifm, wght;
`ifdef PE_FEED_STALL_CNT_EN
    logic [KW-1:0]        stall_cnt;
`endif

    pe_feed_inner_if u_if ();

    pe_feed_inner u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_k    (cfg_k),
        .busy     (busy),
        .done     (done),
        .s_in     (u_if),
        .idx      (idx),
        .mac_done (mac_done),
        .en_i     (en_i),
        .en_w     (en_w),
        .clr_i    (clr_i),
        .clr_w    (clr_w),
        .en_o     (en_o),
        .clr_o    (clr_o),
        .ifm      (ifm),
        .wght     (wght)
`ifdef PE_FEED_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int cyc;

    // Transaction-level reference: a job, its remaining MACs, the start cycle
    // of the most recent MAC window and the cycle its done pulse is due.
    bit         m_active;
    int         m_k_left;
    int         m_job_start;
    int         m_ws;
    bit         m_ws_first;
    bit         m_first;
    int         m_done_at;
    logic [7:0] m_ifm, m_wght;
    int         m_stall;

    bit         seen_done;
    bit         seen_hs;
    int         seen_stall;

    int ops_i [4] = '{5, -128, 1, 77};
    int ops_w [4] = '{-3, 127, 1, -9};

    typedef struct {
        int k;
        int gap;
        bit mid;
        int exp_lat;
        int exp_hs;
        int exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_k_left = 0; m_job_start = -1; m_ws = -1;
        m_ws_first = 0; m_first = 0; m_done_at = NEVER;
        m_ifm = '0; m_wght = '0; m_stall = 0;
    endtask

    // One clock: check this cycle's outputs against the model, then advance the model.
    task automatic step();
        bit e_en_o, e_mac, e_eni, e_clro, e_done, e_busy, e_rdy, e_load, hs;
        int e_idx;
        @(negedge clk);
        e_en_o = (m_ws >= 0) && (cyc >= m_ws) && (cyc < m_ws + IW);
        e_idx  = e_en_o ? (cyc - m_ws) : 0;
        e_mac  = e_en_o && (cyc == m_ws + IW - 1);
        e_eni  = e_en_o && (cyc == m_ws);
        e_clro = e_eni && m_ws_first;
        e_done = (cyc == m_done_at);
        e_busy = m_active && (cyc > m_job_start) && (cyc < m_done_at);
        e_rdy  = m_active && (m_k_left > 0) && (cyc > m_job_start) && (!e_en_o || e_mac);
        e_load = m_active && (m_k_left > 0) && (cyc > m_job_start) && !e_en_o;
        chk("en_o",     32'(en_o),      32'(e_en_o));
        chk("idx",      32'(idx),       32'(e_idx));
        chk("mac_done", 32'(mac_done),  32'(e_mac));
        chk("en_i",     32'(en_i),      32'(e_eni));
        chk("en_w",     32'(en_w),      32'(e_eni));
        chk("clr_o",    32'(clr_o),     32'(e_clro));
        chk("done",     32'(done),      32'(e_done));
        chk("clr_i",    32'(clr_i),     32'(e_done));
        chk("clr_w",    32'(clr_w),     32'(e_done));
        chk("busy",     32'(busy),      32'(e_busy));
        chk("in_ready", 32'(u_if.in_ready), 32'(e_rdy));
        chk("ifm",      {24'd0, ifm},   {24'd0, m_ifm});
        chk("wght",     {24'd0, wght},  {24'd0, m_wght});
`ifdef PE_FEED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        seen_stall = int'(stall_cnt);
`else
        seen_stall = 0;
`endif
        seen_done = done;
        seen_hs   = u_if.in_valid && u_if.in_ready;
        if (!rst_n) begin
            model_reset();
        end else begin
            hs = u_if.in_valid && e_rdy;
            if (e_load && !u_if.in_valid && m_stall < 65535) m_stall++;
            if (!m_active && start) begin
                m_active    = 1;
                m_job_start = cyc;
                m_k_left    = int'(cfg_k);
                m_first     = 1;
                m_stall     = 0;
                m_done_at   = (cfg_k == 0) ? cyc + 2 : NEVER;
            end
            if (hs) begin
                m_ifm      = u_if.in_ifm;
                m_wght     = u_if.in_wght;
                m_ws       = cyc + 1;
                m_ws_first = m_first;
                m_first    = 0;
                m_k_left--;
                if (m_k_left == 0) m_done_at = cyc + IW + 1;
            end
            if (cyc == m_done_at) m_active = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one job; in_valid drops for the last cycle of each window plus
    // 'gap' LOAD cycles when gap > 0.
    task automatic run_job(input int k, input int gap, input bit mid,
                           output int lat, output int nhs, output int stall);
        int t0, pi;
        bit v;
        start = 1; cfg_k = KW'(k); u_if.in_valid = 0;
        t0 = cyc;
        step();
        start = 0;
        lat = -1; nhs = 0; pi = 0; stall = -1;
        for (int n = 0; n < 400 && lat < 0; n++) begin
            v = 1;
            if (gap > 0 && m_ws > t0 && cyc >= m_ws + IW - 1 && cyc <= m_ws + IW + gap - 1) v = 0;
            u_if.in_valid = v;
            u_if.in_ifm   = 8'(ops_i[pi % 4]);
            u_if.in_wght  = 8'(ops_w[pi % 4]);
            start = mid && (cyc == t0 + 5);
            cfg_k = mid ? KW'(7) : KW'(k);
            step();
            if (seen_hs) begin nhs++; pi++; end
            if (seen_done) begin lat = cyc - 1 - t0; stall = seen_stall; end
        end
        start = 0; u_if.in_valid = 0;
        step();
    endtask

    initial begin
        vec_t tbl [6];
        int lat, nhs, stall, t0, ndone;

        tbl[0] = '{3, 0, 1'b0, 26, 3, 0};
        tbl[1] = '{2, 4, 1'b0, 23, 2, 4};
        tbl[2] = '{0, 0, 1'b0,  2, 0, 0};
        tbl[3] = '{5, 0, 1'b1, 42, 5, 0};
        tbl[4] = '{1, 0, 1'b0, 10, 1, 0};
        tbl[5] = '{3, 1, 1'b0, 30, 3, 2};

        n_checks = 0; n_fail = 0;
        model_reset();
        rst_n = 0; start = 0; cfg_k = '0;
        u_if.in_valid = 0; u_if.in_ifm = '0; u_if.in_wght = '0;
        @(posedge clk);
        #1;
        cyc = 0;
        step(); step(); step();
        rst_n = 1;
        step(); step();

        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].k, tbl[i].gap, tbl[i].mid, lat, nhs, stall);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_pairs", i), 32'(nhs), 32'(tbl[i].exp_hs));
`ifdef PE_FEED_STALL_CNT_EN
            chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
`endif
            step();
        end

        // Reset at idx 4 of the second MAC aborts the job with no done pulse.
        start = 1; cfg_k = KW'(3); u_if.in_valid = 1;
        u_if.in_ifm = 8'sd9; u_if.in_wght = -8'sd2;
        t0 = cyc;
        step();
        start = 0;
        for (int n = 0; n < 100 && !(m_k_left == 1 && cyc == m_ws + 4); n++) step();
        chk("abort_reached_idx4", 32'(idx), 32'd4);
        rst_n = 0;
        step();
        rst_n = 1;
        u_if.in_valid = 0;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (seen_done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_job_len", 32'(cyc - t0 > 30), 32'd1);
        run_job(2, 0, 1'b0, lat, nhs, stall);
        chk("after_abort_latency", 32'(lat), 32'd18);
        chk("after_abort_pairs", 32'(nhs), 32'd2);

        // Randomized traffic, including stray starts and occasional resets.
        for (int n = 0; n < 2500; n++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            start         = ($urandom_range(0, 9) == 0);
            cfg_k         = KW'($urandom_range(0, 3));
            u_if.in_valid = ($urandom_range(0, 3) != 0);
            u_if.in_ifm   = 8'($urandom);
            u_if.in_wght  = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_feed_inner.md
# pe_feed_inner

Operand feeder and sequencer for the binary-serial inner-product PE. It accepts one ifm/wght operand pair per MAC through a valid/ready handshake and sequences each MAC over IWIDTH bit-serial cycles. It drives the PE's operand, idx, mac_done and en/clr control inputs, and marks job start/end for a run of cfg_k MACs. It sits directly upstream of the PE, at the array edge.

## Interface
- IWIDTH, 8: operand width; also the number of bit-serial cycles per MAC.
- IDEPTH, 3: idx width, equal to clog2(IWIDTH).
- KWIDTH, 16: width of the MAC-count field.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  job request; accepted only in IDLE.
- cfg_k  in  KWIDTH  MACs per job; latched on start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle job-complete pulse.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_ifm, in_wght  in  IWIDTH signed  operand pair.
- idx  out  IDEPTH  bit index to the PE.
- mac_done  out  1  final bit cycle of each MAC.
- en_i, en_w  out  1  operand-register load strobes.
- clr_i, clr_w  out  1  operand-register clears.
- en_o, clr_o  out  1  accumulator enable and clear.
- ifm, wght  out  IWIDTH signed  operands to the PE.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE
  - start=1 and cfg_k>0: latch cfg_k into k_left, go to LOAD.
  - start=1 and cfg_k=0: go to FIN; no PE activity.
- LOAD
  - in_ready=1.
  - On handshake: capture the operands, decrement k_left, go to RUN with cnt=0.
  - Without handshake: stay in LOAD, with en_o=0 and idx=0.
- RUN
  - cnt counts 0..IWIDTH-1; the registered output idx equals cnt.
  - At cnt=IWIDTH-1:
    - k_left>0: in_ready=1. A handshake restarts RUN at cnt=0 with no gap; no handshake goes to LOAD.
    - k_left=0: go to FIN.
- FIN: done=1 and clr_i=clr_w=1 for one cycle, then IDLE.
- start while not IDLE is ignored.
- in_ready is combinational from state, cnt and k_left. It never depends on in_valid.
- ifm and wght hold their last captured value until the next capture.
- k_left arithmetic is unsigned KWIDTH. It is never decremented below 0.

## Timing
- All PE-facing outputs and done/busy are registered. in_ready is the only combinational output.
- Handshake in cycle t gives an output window over cycles t+1..t+IWIDTH:
  - t+1: en_i=en_w=1, ifm/wght = captured pair, idx=0.
  - t+1..t+IWIDTH: en_o=1, idx increments by 1 per cycle.
  - t+IWIDTH: mac_done=1.
- clr_o=1 only in the first cycle of the first window of each job.
- Back-to-back MACs have a period of exactly IWIDTH cycles.
- done asserts in the cycle after the last window's final cycle. busy deasserts in the same cycle.
- Reset, including mid-job: at the next edge the FSM goes to IDLE, k_left and cnt go to 0, and every output is 0 (in_ready=0 in IDLE). No done is issued for an aborted job.
- Job latency with in_valid held high: 1 + cfg_k·IWIDTH + 1 cycles from start to done.

## Configuration
- PE_FEED_STALL_CNT_EN
  - Defined: adds output stall_cnt [KWIDTH-1:0]. It counts cycles with state=LOAD and in_valid=0, clears on start acceptance, saturates at all-ones, and resets to 0.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package pe_feed_pkg:
  - state enum typedef pe_feed_state_t.
  - localparam for the last idx value, IWIDTH-1.
- Sub-module pe_feed_idx_cnt: IDEPTH-bit counter with clear, enable and last flag; its registered value drives idx.
- Top: FSM, k_left register, operand capture registers and output registers.

## Test plan
- cfg_k=3, in_valid held high, pairs (5,-3), (-128,127), (1,1) -> three contiguous 8-cycle windows; idx 0..7 in each; mac_done at window cycles 8, 16, 24; clr_o only in cycle 1; done 26 cycles after start.
- cfg_k=2, in_valid low for 4 cycles between pairs -> LOAD holds with en_o=0 for 4 cycles; second window starts 1 cycle after the handshake; stall_cnt=4 when the macro is defined.
- cfg_k=0 -> done pulses the cycle after FIN is entered; en_i, en_w and en_o never assert.
- start pulsed during RUN with cfg_k=5 -> ignored; original job completes its MAC count unchanged.
- rst_n low at idx=4 of MAC 2 -> next edge: all outputs 0, state IDLE, no done; a new job then runs normally.
- cfg_k=1, in_valid at cnt=IWIDTH-1 -> in_ready stays 0 there (k_left=0); FIN follows; done and clr_i/clr_w pulse together.
